// File: rtl/nibble_serial_adder_pkg.sv
// Shared encodings and sizing helpers for the nibble-serial adder and its CLA slice.
package nibble_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NIB_W = 4;

  // Nibble index width; a single-nibble operand still needs one bit.
  function automatic int idx_width(input int nib);
    return (nib <= 1) ? 1 : $clog2(nib);
  endfunction

endpackage

// File: rtl/nibble_serial_adder_cla4_slice.sv
// Purely combinational 4-bit carry-lookahead adder slice.
module cla4_slice
  import nibble_adder_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout
);

  logic [NIB_W-1:0] g, p;
  logic [NIB_W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is flattened to generate/propagate terms of cin.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s    = p ^ c[NIB_W-1:0];
  assign cout = c[NIB_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that feeds one 4-bit CLA slice a nibble per cycle, LSB first.
// Define NIBBLE_ADDSUB_EN to add the in_sub port (A-B via ~B and forced carry-in).
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
`ifdef NIBBLE_ADDSUB_EN
  input  logic             in_sub,
`endif
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int NIB = WIDTH / NIB_W;
  localparam int IW  = idx_width(NIB);
  localparam logic [IW-1:0] IDX_LAST = IW'(NIB - 1);

  state_t           state, state_nx;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic             sub_op;
  logic [NIB_W-1:0] sl_a, sl_b, sl_s;
  logic             sl_cout;
  logic             accept;

`ifdef NIBBLE_ADDSUB_EN
  assign sub_op = in_sub;
`else
  assign sub_op = 1'b0;
`endif

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign out_cout  = (state == ST_DONE) ? carry : 1'b0;
  assign out_sum   = sum_reg;
  assign accept    = in_valid & in_ready;

  assign sl_a = a_reg[NIB_W*idx +: NIB_W];
  assign sl_b = b_reg[NIB_W*idx +: NIB_W];

  cla4_slice u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry),
    .s    (sl_s),
    .cout (sl_cout)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept)          state_nx = ST_RUN;
      ST_RUN:  if (idx == IDX_LAST) state_nx = ST_DONE;
      ST_DONE: if (out_ready)       state_nx = ST_IDLE;
      default:                      state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      carry   <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: if (accept) begin
          // Subtract folds into the add path: ~B plus a forced carry of one.
          a_reg   <= in_a;
          b_reg   <= in_b ^ {WIDTH{sub_op}};
          carry   <= sub_op | in_cin;
          sum_reg <= '0;
          idx     <= '0;
        end
        ST_RUN: begin
          sum_reg[NIB_W*idx +: NIB_W] <= sl_s;
          carry                       <= sl_cout;
          if (idx != IDX_LAST) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
